addmuladd_share_arbiter: RTL and testbench
==========================================

# addmuladd_share_arbiter

Shares one pipelined signed add-multiply-add DSP datapath, computing `((d + a) * b) + c`, between `N_REQ` independent requesters. Requests are granted round-robin and issued at up to one operation per cycle. Each result returns on a single valid/ready output port, tagged with the index of the requester that issued it. The block sits between per-lane operand producers and the DSP slice, so several lanes can use one mapped DSP.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 11: signed operand and result width.
- `PIPE_DEPTH`, 1: datapath register stages, 1..4. The final stage is the output register.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid` input N_REQ: per-requester operand valid.
- `req_ready` output N_REQ: per-requester accept; at most one bit is high in any cycle.
- `req_a`, `req_b`, `req_c`, `req_d` input N_REQ*WIDTH each: signed operands. Requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `res_valid` output 1: result valid.
- `res_ready` input 1: downstream accept.
- `res_data` output WIDTH: signed result.
- `res_id` output clog2(N_REQ): index of the requester that issued the result.

## Operation
- Advance condition: `adv = !res_valid || res_ready`. It is global; every pipeline stage moves together or holds together.
- Arbitration, round-robin:
  - The pointer `last` (index of the last granted requester) resets to N_REQ-1, so requester 0 has first priority.
  - The search starts at `last+1` mod N_REQ and takes the first requester with `req_valid` high.
- Grant:
  - `req_ready[g] = adv && req_valid[g]` for the searched winner g; all other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid` and `res_ready`.
- Transfer: happens when `req_valid[g] && req_ready[g]`.
  - Operands of g and tag g enter stage 1; `last <= g`.
  - With no transfer, `last` holds.
- Pipeline:
  - Each stage carries valid, id and data.
  - On `adv`, stage k+1 takes stage k; stage 1 takes the new transfer, or valid=0 if there is none.
  - The last stage drives `res_valid`, `res_id` and `res_data`.
- Arithmetic:
  - Computed at full precision: `d+a` is WIDTH+1 bits, the product is 2*WIDTH+1 bits, the sum is 2*WIDTH+2 bits, all sign-extended.
  - `res_data` is the low WIDTH bits (modulo 2^WIDTH wrap), unless saturation is enabled (see Configuration).
- Output stability: while `res_valid && !res_ready`, `res_data` and `res_id` hold unchanged and every `req_ready` is 0.
- Reset values, asynchronous assertion, all registers:
  - `res_valid`=0, `res_data`=0, `res_id`=0.
  - All stage valids 0; `last`=N_REQ-1.
  - `req_ready` is 0 while `rst` is high.
- Reset mid-operation drops every in-flight operation without emitting it.

## Timing
- Latency: a transfer at rising edge k produces `res_valid`=1 after edge k+PIPE_DEPTH-1 when no stall occurs. With PIPE_DEPTH=1, the result is visible in the cycle after the accepting edge.
- Throughput: one operation per cycle while `res_ready` is held high.
- Stall: each cycle with `res_valid && !res_ready` adds exactly one cycle to the latency of every in-flight operation.
- Bubbles: empty stages are not compressed. A bubble propagates like an operation, but it never blocks `adv`.
- Fairness: with all requesters continuously valid and no stalls, each requester is granted exactly once per N_REQ consecutive cycles.
- Single requester: a lone valid requester is granted every cycle regardless of `last`.

## Configuration
- `ADDMULADD_ARB_SAT_EN` defined:
  - The full-precision sum is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before the output stage.
  - The clamp adds no cycles.
- Not defined: low-WIDTH-bit wrap, with no clamp logic instantiated.

## Test plan
- Basic op: req 0 with a=3, b=4, c=5, d=2 and `res_ready`=1 -> one cycle later `res_valid`=1, `res_data`=25, `res_id`=0.
- Round-robin: all four requesters valid continuously and `res_ready`=1 -> `req_ready` grants 0,1,2,3,0,1,…; `res_id` follows the same sequence one cycle later.
- Backpressure: `res_valid`=1 with `res_ready`=0 for 3 cycles -> `res_data`/`res_id` are stable and `req_ready`=0 for those 3 cycles; the next result appears on the cycle after `res_ready` returns to 1.
- Overflow: a=1023, d=1023, b=1023, c=0 -> `res_data`=2 without the macro, 1023 with `ADDMULADD_ARB_SAT_EN`. a=-1024, d=-1024, b=1023, c=0 -> 0 without, -1024 with.
- Reset mid-op: assert `rst` while `res_valid`=1 -> `res_valid`/`res_data`/`res_id` go to 0 asynchronously; after release with all valid, requester 0 is granted first.
- Single requester: only req 2 valid for 5 cycles -> `req_ready[2]`=1 every cycle, 5 consecutive results with `res_id`=2.

Source files
------------

// File: rtl/addmuladd_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : addmuladd_share_arbiter
// Description : Round-robin arbiter sharing one pipelined signed
//               ((d + a) * b) + c datapath between N_REQ requesters.
//               Results leave on one valid/ready port tagged with the
//               issuing requester index. All stages advance or hold together.
//               Optional macro ADDMULADD_ARB_SAT_EN clamps the full-precision
//               result to the signed WIDTH range instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module addmuladd_share_arbiter #(
   parameter int N_REQ      = 4,
   parameter int WIDTH      = 11,
   parameter int PIPE_DEPTH = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*WIDTH-1:0]     req_a,
   input  logic [N_REQ*WIDTH-1:0]     req_b,
   input  logic [N_REQ*WIDTH-1:0]     req_c,
   input  logic [N_REQ*WIDTH-1:0]     req_d,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [WIDTH-1:0]           res_data,
   output logic [$clog2(N_REQ)-1:0]   res_id
);

   localparam int                c_id_w    = $clog2(N_REQ);
   localparam logic [c_id_w-1:0] c_last_rst = c_id_w'(N_REQ - 1);

   // Round-robin pointer: index of the most recently granted requester.
   logic [c_id_w-1:0] r_last;

   // Per-stage pipeline state; the last stage is the output register.
   logic              r_vld [PIPE_DEPTH];
   logic [c_id_w-1:0] r_id  [PIPE_DEPTH];
   logic [WIDTH-1:0]  r_dat [PIPE_DEPTH];

   logic              w_adv;
   logic              w_found;
   logic [c_id_w-1:0] w_gnt;
   logic              w_xfer;
   logic [WIDTH-1:0]  w_a;
   logic [WIDTH-1:0]  w_b;
   logic [WIDTH-1:0]  w_c;
   logic [WIDTH-1:0]  w_d;
   logic [WIDTH-1:0]  w_res;

   // Wrap-around index helper for the rotating priority search.
   function automatic logic [c_id_w-1:0] f_wrap(input logic [c_id_w-1:0] base,
                                                input int                off);
      int t;
      t = (int'(base) + off) % N_REQ;
      return t[c_id_w-1:0];
   endfunction

   assign res_valid = r_vld[PIPE_DEPTH-1];
   assign res_id    = r_id[PIPE_DEPTH-1];
   assign res_data  = r_dat[PIPE_DEPTH-1];

   // The whole pipeline moves unless a held result is still unaccepted.
   assign w_adv = !res_valid || res_ready;

   // Rotating-priority search starting one past the last winner.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!w_found && req_valid[f_wrap(r_last, k)]) begin
            w_found = 1'b1;
            w_gnt   = f_wrap(r_last, k);
         end
      end
   end

   // One-hot accept to the winner only when the pipeline can take it.
   always_comb begin
      req_ready = '0;
      if (w_found && w_adv && !rst) begin
         req_ready[w_gnt] = 1'b1;
      end
   end

   assign w_xfer = |req_ready;

   // Select the winner's operand lanes.
   always_comb begin
      w_a = '0;
      w_b = '0;
      w_c = '0;
      w_d = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt == c_id_w'(i)) begin
            w_a = req_a[i*WIDTH +: WIDTH];
            w_b = req_b[i*WIDTH +: WIDTH];
            w_c = req_c[i*WIDTH +: WIDTH];
            w_d = req_d[i*WIDTH +: WIDTH];
         end
      end
   end

`ifdef ADDMULADD_ARB_SAT_EN
   localparam logic signed [2*WIDTH+1:0] c_sat_max =
      {{(WIDTH+3){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH+1:0] c_sat_min =
      {{(WIDTH+3){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [WIDTH:0]     w_pre;
   logic signed [2*WIDTH:0]   w_prod;
   logic signed [2*WIDTH+1:0] w_full;

   // Full-precision pre-add, multiply and post-add, then clamp to WIDTH.
   always_comb begin
      w_pre  = $signed({w_d[WIDTH-1], w_d}) + $signed({w_a[WIDTH-1], w_a});
      w_prod = $signed({{WIDTH{w_pre[WIDTH]}}, w_pre}) *
               $signed({{(WIDTH+1){w_b[WIDTH-1]}}, w_b});
      w_full = $signed({w_prod[2*WIDTH], w_prod}) +
               $signed({{(WIDTH+2){w_c[WIDTH-1]}}, w_c});
      if (w_full > c_sat_max) begin
         w_res = c_sat_max[WIDTH-1:0];
      end else if (w_full < c_sat_min) begin
         w_res = c_sat_min[WIDTH-1:0];
      end else begin
         w_res = w_full[WIDTH-1:0];
      end
   end
`else
   // Wrapped result: the low WIDTH bits only depend on low WIDTH-bit arithmetic.
   always_comb begin
      w_res = (w_d + w_a) * w_b + w_c;
   end
`endif

   // Pointer follows each accepted transfer and holds otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= c_last_rst;
      end else if (w_xfer) begin
         r_last <= w_gnt;
      end
   end

   // Lock-step pipeline shift; stage 0 loads the new transfer or a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < PIPE_DEPTH; s++) begin
            r_vld[s] <= 1'b0;
            r_id[s]  <= '0;
            r_dat[s] <= '0;
         end
      end else if (w_adv) begin
         r_vld[0] <= w_xfer;
         if (w_xfer) begin
            r_id[0]  <= w_gnt;
            r_dat[0] <= w_res;
         end
         for (int s = 1; s < PIPE_DEPTH; s++) begin
            r_vld[s] <= r_vld[s-1];
            r_id[s]  <= r_id[s-1];
            r_dat[s] <= r_dat[s-1];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_addmuladd_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_addmuladd_share_arbiter
// Description : Self-checking bench for addmuladd_share_arbiter. A scoreboard
//               model (queue of in-flight results with pipeline age) is
//               compared on every cycle; directed phases pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addmuladd_share_arbiter;

   localparam int N_REQ      = 4;
   localparam int WIDTH      = 11;
   localparam int PIPE_DEPTH = 1;
   localparam int IDW        = $clog2(N_REQ);

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a, req_b, req_c, req_d;
   logic                   res_valid;
   logic                   res_ready;
   logic [WIDTH-1:0]       res_data;
   logic [IDW-1:0]         res_id;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int               id;
      logic [WIDTH-1:0] data;
      int               age;
   } ent_t;

   ent_t q[$];

   always #5 clk = ~clk;

   addmuladd_share_arbiter #(
      .N_REQ      (N_REQ),
      .WIDTH      (WIDTH),
      .PIPE_DEPTH (PIPE_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .req_d     (req_d),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Spec-level result: full-precision arithmetic, then wrap or clamp.
   function automatic logic [WIDTH-1:0] f_model(input int i);
      logic signed [WIDTH-1:0] a, b, c, d;
      longint full;
      longint lim;
      a = req_a[i*WIDTH +: WIDTH];
      b = req_b[i*WIDTH +: WIDTH];
      c = req_c[i*WIDTH +: WIDTH];
      d = req_d[i*WIDTH +: WIDTH];
      full = (longint'(d) + longint'(a)) * longint'(b) + longint'(c);
      lim  = longint'(1) <<< (WIDTH - 1);
`ifdef ADDMULADD_ARB_SAT_EN
      if (full > lim - 1) full = lim - 1;
      else if (full < -lim) full = -lim;
`endif
      return full[WIDTH-1:0];
   endfunction

   task automatic set_op(input int i, input int a, input int b, input int c, input int d);
      req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
      req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
      req_c[i*WIDTH +: WIDTH] = WIDTH'(c);
      req_d[i*WIDTH +: WIDTH] = WIDTH'(d);
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N_REQ; i++) begin
         set_op(i, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: compare at negedge, update model state at posedge.
   initial begin : model
      int   m_last;
      int   g;
      int   idx;
      bit   e_valid, e_adv, p_xfer;
      logic [N_REQ-1:0] e_ready;
      ent_t p_ent, tmp;
      m_last = N_REQ - 1;
      forever begin
         @(negedge clk);
         p_xfer = 1'b0;
         e_adv  = 1'b0;
         e_valid = 1'b0;
         if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_res_valid", 64'(res_valid), 64'(0));
         end else begin
            e_valid = (q.size() > 0) && (q[0].age == PIPE_DEPTH);
            chk("m_res_valid", 64'(res_valid), 64'(e_valid));
            if (e_valid) begin
               chk("m_res_data", 64'(res_data), 64'(q[0].data));
               chk("m_res_id", 64'(res_id), 64'(q[0].id));
            end
            e_adv = !e_valid || res_ready;
            g = -1;
            for (int k = 1; k <= N_REQ; k++) begin
               idx = (m_last + k) % N_REQ;
               if (g < 0 && req_valid[idx]) g = idx;
            end
            e_ready = '0;
            if (e_adv && g >= 0) e_ready[g] = 1'b1;
            chk("m_req_ready", 64'(req_ready), 64'(e_ready));
            if (e_adv && g >= 0) begin
               p_xfer     = 1'b1;
               p_ent.id   = g;
               p_ent.data = f_model(g);
               p_ent.age  = 0;
            end
         end
         @(posedge clk);
         if (rst) begin
            q.delete();
            m_last = N_REQ - 1;
         end else if (e_adv) begin
            if (e_valid) void'(q.pop_front());
            if (p_xfer) begin
               q.push_back(p_ent);
               m_last = p_ent.id;
            end
            for (int j = 0; j < q.size(); j++) begin
               tmp = q[j];
               tmp.age++;
               q[j] = tmp;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Directed phases with hand-computed expectations, plus random traffic.
   initial begin : stim
      int rr [8];
      logic [WIDTH-1:0] e_ovf1, e_ovf2;
`ifdef ADDMULADD_ARB_SAT_EN
      e_ovf1 = WIDTH'(1023);
      e_ovf2 = WIDTH'(-1024);
`else
      e_ovf1 = WIDTH'(2);
      e_ovf2 = WIDTH'(0);
`endif
      rr = '{1, 2, 3, 0, 1, 2, 3, 0};

      rst       = 1'b1;
      req_valid = '1;
      res_ready = 1'b1;
      req_a = '0; req_b = '0; req_c = '0; req_d = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_res_valid", 64'(res_valid), 64'(0));
      chk("reset_res_data", 64'(res_data), 64'(0));
      chk("reset_res_id", 64'(res_id), 64'(0));
      chk("reset_req_ready", 64'(req_ready), 64'(0));

      // Basic op: (2+3)*4+5 = 25 from requester 0.
      step();
      rst       = 1'b0;
      req_valid = 4'b0001;
      set_op(0, 3, 4, 5, 2);
      @(negedge clk);
      chk("basic_grant", 64'(req_ready), 64'(4'b0001));
      step();
      req_valid = '0;
      @(negedge clk);
      chk("basic_valid", 64'(res_valid), 64'(1));
      chk("basic_data", 64'(res_data), 64'(25));
      chk("basic_id", 64'(res_id), 64'(0));

      // Round-robin with all valid; last grant was 0.
      for (int k = 0; k < 8; k++) begin
         step();
         req_valid = '1;
         rand_ops();
         @(negedge clk);
         chk("rr_grant", 64'(req_ready), 64'(1 << rr[k]));
         if (k > 0) chk("rr_id", 64'(res_id), 64'(rr[k-1]));
      end

      // Backpressure for 3 cycles while holding result id 0.
      step();
      res_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) step();
         @(negedge clk);
         chk("bp_ready", 64'(req_ready), 64'(0));
         chk("bp_valid", 64'(res_valid), 64'(1));
         chk("bp_id", 64'(res_id), 64'(0));
      end
      step();
      res_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_grant", 64'(req_ready), 64'(4'b0010));

      // Overflow cases on requester 0.
      step();
      req_valid = 4'b0001;
      set_op(0, 1023, 1023, 0, 1023);
      @(negedge clk);
      chk("bp_next_valid", 64'(res_valid), 64'(1));
      chk("bp_next_id", 64'(res_id), 64'(1));
      step();
      set_op(0, -1024, 1023, 0, -1024);
      @(negedge clk);
      chk("ovf_pos_data", 64'(res_data), 64'(e_ovf1));
      step();
      req_valid = '0;
      @(negedge clk);
      chk("ovf_neg_data", 64'(res_data), 64'(e_ovf2));

      // Single requester 2 for 5 cycles.
      for (int k = 0; k < 6; k++) begin
         step();
         if (k < 5) begin
            req_valid = 4'b0100;
            rand_ops();
         end else begin
            req_valid = '0;
         end
         @(negedge clk);
         if (k < 5) chk("single_grant", 64'(req_ready), 64'(4'b0100));
         if (k > 0) begin
            chk("single_valid", 64'(res_valid), 64'(1));
            chk("single_id", 64'(res_id), 64'(2));
         end
      end

      // Random traffic with random backpressure.
      repeat (600) begin
         step();
         req_valid = N_REQ'($urandom);
         rand_ops();
         res_ready = ($urandom_range(0, 3) != 0);
      end

      // Reset while a result is being presented.
      step();
      req_valid = '1;
      res_ready = 1'b1;
      step();
      #1;
      chk("mid_valid_before", 64'(res_valid), 64'(1));
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(res_valid), 64'(0));
      chk("mid_rst_data", 64'(res_data), 64'(0));
      chk("mid_rst_id", 64'(res_id), 64'(0));
      step();
      step();
      rst       = 1'b0;
      req_valid = '1;
      @(negedge clk);
      chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));
      step();
      req_valid = '0;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
